// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the iterative RV32M multiply/divide unit.
//   * RV32M funct3 op encodings
//   * FSM state enum (IDLE / CALC / DONE)
//   * iteration count and the fixed results of the divide special cases
// -----------------------------------------------------------------------------
package mdu_pkg;

   localparam int OP_W = 3;
   localparam int RD_W = 5;

   localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
   localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
   localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
   localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
   localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
   localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
   localparam logic [OP_W-1:0] OP_REM    = 3'b110;
   localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One radix-2 step per CALC cycle.
   localparam int ITER_CNT = 32;
   localparam int CNT_W    = $clog2(ITER_CNT);

   // Divide-by-zero and signed-overflow results (RISC-V semantics).
   localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
   localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
   localparam logic [31:0] OVF_REM  = 32'h0000_0000;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/mdu_iter_if.sv
// -----------------------------------------------------------------------------
// mdu_iter_if -- request/response bundle of the multiply/divide unit.
//   master (issuing pipeline): start, op, src1, src2, rd_in, flush
//   slave  (mdu_iter)        : busy, done, result, rd_out
// -----------------------------------------------------------------------------
interface mdu_iter_if
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   logic [OP_W-1:0] op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [RD_W-1:0] rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [RD_W-1:0] rd_out;

   modport master (
      output start, op, src1, src2, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, op, src1, src2, rd_in, flush,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/mdu_div_core.sv
// -----------------------------------------------------------------------------
// mdu_div_core -- restoring divider on unsigned magnitudes plus the shared
// iteration counter.
//   clr      : abort, clears all state
//   load     : capture dividend/divisor, zero remainder and counter
//   step     : one radix-2 restoring step, counter increments
//   last     : the current step is the final one (counter == ITER_CNT-1)
//   quo_nx / rem_nx : quotient / remainder after the current step
// -----------------------------------------------------------------------------
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        last,
   output logic [31:0] quo_nx,
   output logic [31:0] rem_nx
);
   logic [31:0]      rem_q;
   logic [31:0]      quo_q;    // dividend bits shift out the top, quotient bits in the bottom
   logic [31:0]      dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic [32:0]      shifted;
   logic             fits;

   always_comb begin
      shifted = {rem_q, quo_q[31]};
      fits    = shifted >= {1'b0, dvs_q};
      // When the divisor fits, the true difference is below the divisor,
      // so a 32-bit subtraction is exact.
      rem_nx  = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
      quo_nx  = {quo_q[30:0], fits};
   end

   assign last = (cnt_q == CNT_W'(ITER_CNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
      end else if (step) begin
         rem_q <= rem_nx;
         quo_q <= quo_nx;
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative RV32M multiply/divide unit (32 radix-2 steps).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mdu_iter_if.slave (start/op/src1/src2/rd_in/flush in,
//                busy/done/result/rd_out out)
// Divide by zero and signed overflow complete without iterating.
// Optional macro MDU_FAST_MUL_EN: all multiplies use a single-cycle 33x33
// signed multiply and complete without iterating.
// -----------------------------------------------------------------------------
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst_n,
   mdu_iter_if.slave bus
);
   state_e          state_q, state_d;
   logic [2:0]      op_q;
   logic [RD_W-1:0] rd_q, rd_out_q;
   logic            neg_q;
   logic [63:0]     mcand_q, prod_q, prod_nx, prod_fix;
   logic [XLEN-1:0] mplr_q, result_q;

   logic            accept, is_div_op, sx1, sx2, neg_d;
   logic            div_zero, div_ovf, bypass, last;
   logic [XLEN-1:0] mag1, mag2, bypass_val, final_val;
   logic [31:0]     quo_nx, rem_nx;

   // Request decode: signedness, magnitudes, result sign, special cases.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      accept    = bus.start && !bus.flush && (state_q != ST_CALC);
      is_div_op = bus.op[2];
      sx1       = is_div_op ? !bus.op[0] : (bus.op == OP_MULH || bus.op == OP_MULHSU);
      sx2       = is_div_op ? !bus.op[0] : (bus.op == OP_MULH);
      mag1      = (sx1 && bus.src1[31]) ? -bus.src1 : bus.src1;
      mag2      = (sx2 && bus.src2[31]) ? -bus.src2 : bus.src2;
      // REM takes the dividend's sign; products and quotients the XOR.
      neg_d     = (is_div_op && bus.op[1]) ? (sx1 && bus.src1[31])
                : ((sx1 && bus.src1[31]) ^ (sx2 && bus.src2[31]));
      div_zero  = is_div_op && (bus.src2 == '0);
      div_ovf   = is_div_op && sx1 && (bus.src1 == INT_MIN) && (bus.src2 == '1);
      bypass    = div_zero || div_ovf;
      bypass_val = '0;
      if (div_zero)     bypass_val = bus.op[1] ? bus.src1 : DIV0_QUO;
      else if (div_ovf) bypass_val = bus.op[1] ? OVF_REM : OVF_QUO;
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [63:0] fast_a, fast_b, fast_p;
   logic               fast_mul;

   always_comb begin
      fast_a   = {{32{sx1 & bus.src1[31]}}, bus.src1};
      fast_b   = {{32{sx2 & bus.src2[31]}}, bus.src2};
      fast_p   = fast_a * fast_b;
      fast_mul = !is_div_op;
   end
`endif

   // Shift-add step on magnitudes, then sign correction of the final sum.
   always_comb begin
      prod_nx  = prod_q + (mplr_q[0] ? mcand_q : 64'd0);
      prod_fix = neg_q ? -prod_nx : prod_nx;
      if (op_q[2])
         final_val = op_q[1] ? (neg_q ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
      else
         final_val = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) state_d = ST_IDLE;
      else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (!bus.start)   state_d = ST_IDLE;
`ifdef MDU_FAST_MUL_EN
               else if (bypass || fast_mul) state_d = ST_DONE;
`else
               else if (bypass)  state_d = ST_DONE;
`endif
               else              state_d = ST_CALC;
            end
            ST_CALC: if (last) state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   mdu_div_core u_div_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.flush),
      .load     (accept),
      .step     (state_q == ST_CALC),
      .dividend (mag1),
      .divisor  (mag2),
      .last     (last),
      .quo_nx   (quo_nx),
      .rem_nx   (rem_nx)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: the datapath registers are reset too, so a reset mid-operation
   // leaves no stale operands behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         prod_q   <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= bus.op;
            rd_q    <= bus.rd_in;
            neg_q   <= neg_d;
            mcand_q <= {32'd0, mag1};
            mplr_q  <= mag2;
            prod_q  <= '0;
            if (bypass) begin
               result_q <= bypass_val;
               rd_out_q <= bus.rd_in;
            end
`ifdef MDU_FAST_MUL_EN
            else if (fast_mul) begin
               result_q <= (bus.op == OP_MUL) ? fast_p[31:0] : fast_p[63:32];
               rd_out_q <= bus.rd_in;
            end
`endif
         end else if (state_q == ST_CALC && !bus.flush) begin
            prod_q  <= prod_nx;
            mcand_q <= {mcand_q[62:0], 1'b0};
            mplr_q  <= {1'b0, mplr_q[XLEN-1:1]};
            if (last) begin
               result_q <= final_val;
               rd_out_q <= rd_q;
            end
         end
      end
   end

   assign bus.busy   = (state_q == ST_CALC);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; operands, op and rd_in are sampled on the edge where start=1 and the block accepts.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 src1  input  32  operand rs1, from register-file read port Data1.
REQ-007 src2  input  32  operand rs2, from register-file read port Data2.
REQ-008 rd_in  input  5  destination register tag.
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 busy  output  1  high while in CALC.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  32  registered result, valid from done onward.
REQ-013 rd_out  output  5  tag captured at accept, valid with result.

Function
REQ-014 FSM SHALL have states IDLE, CALC and DONE, with busy = (state==CALC) and done = (state==DONE).
REQ-015 Start SHALL be accepted only in IDLE or DONE (back-to-back); start in CALC SHALL be ignored with no side effect.
REQ-016 Normal ops SHALL run: accept edge E0 -> CALC; edges E1..E32 each perform one radix-2 step; E32 -> DONE; done high for exactly one cycle between E32 and E33; then IDLE unless a new start is accepted.
REQ-017 Multiply SHALL be iterative shift-add on operand magnitudes into a 64-bit product, with sign correction applied at E32 (signed for MULH, src1-signed/src2-unsigned for MULHSU, unsigned for MULHU).
REQ-018 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-019 Divide SHALL use restoring division on magnitudes; the quotient sign SHALL be src1 XOR src2 and the remainder SHALL take the sign of src1 (RISC-V truncation).
REQ-020 Divide by zero SHALL bypass CALC (E0 -> DONE): DIV/DIVU return 0xFFFFFFFF; REM/REMU return src1.
REQ-021 Signed overflow (DIV/REM with src1=0x80000000, src2=0xFFFFFFFF) SHALL bypass CALC: DIV returns 0x80000000; REM returns 0.
REQ-022 result and rd_out SHALL hold their value from DONE until the next DONE.
REQ-023 Flush SHALL force IDLE on the next edge from any state, with no done pulse and result unchanged; flush together with start SHALL leave the start unaccepted.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, result=0, rd_out=0, and clear the iteration counter and the datapath registers, including mid-operation.
REQ-025 An operation interrupted by reset SHALL never produce done.

Configuration
REQ-026 Macro MDU_FAST_MUL_EN: when defined, all four multiply ops SHALL use a single-cycle 33x33 signed multiply and go E0 -> DONE (done one cycle after accept); when undefined, multiply SHALL follow REQ-016/017; divide behaviour SHALL be identical either way.

Structure
REQ-027 Package mdu_pkg SHALL hold the op encodings, the state enum (IDLE/CALC/DONE), the ITER_CNT=32 constant and the divide-by-zero/overflow result constants.
REQ-028 Iterative divider datapath (partial remainder, quotient shift, counter) SHALL be sub-module mdu_div_core; multiply, sign handling and the FSM SHALL stay in mdu_iter.

Verification
REQ-029 MUL src1=7, src2=6, rd_in=5 -> done 33 cycles after accept (1 with MDU_FAST_MUL_EN); result=42; rd_out=5.
REQ-030 MULH src1=0x80000000, src2=0x80000000 -> result=0x40000000; MULHU src1=src2=0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-031 DIV src1=-7, src2=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFF (-1); REMU src1=7, src2=0 -> result=7 with done one cycle after accept.
REQ-032 DIV src1=0x80000000, src2=0xFFFFFFFF -> result=0x80000000 with done one cycle after accept, busy never high.
REQ-033 Start DIVU 100/3 and re-assert start in cycle 10 with different operands -> second start ignored; result=33.
REQ-034 Start DIVU, then drop rst_n in cycle 15 -> busy=0, result=0 immediately, no done pulse; a new DIVU 9/3 then yields result=3.
